// File: rtl/lcd_pkg.sv
// Shared types, LCD command bytes and page text ROM for the LCD page sequencer.
// Optional button debounce is enabled with LCD_BTN_DEBOUNCE_EN.
package lcd_pkg;

  typedef enum logic [3:0] {
    S_PWRUP,
    S_INIT,
    S_CLEAR,
    S_ADDR0,
    S_LINE0,
    S_ADDR1,
    S_LINE1,
    S_DONE,
    S_IDLE
  } lcd_state_e;

  typedef enum logic [1:0] {
    W_IDLE,
    W_SETUP,
    W_EN,
    W_WAIT
  } wr_state_e;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_NEXT,
    EV_PREV,
    EV_OK
  } lcd_ev_e;

  localparam logic [7:0] LCD_CMD_FUNC  = 8'h38;
  localparam logic [7:0] LCD_CMD_DISP  = 8'h0C;
  localparam logic [7:0] LCD_CMD_ENTRY = 8'h06;
  localparam logic [7:0] LCD_CMD_CLEAR = 8'h01;
  localparam logic [7:0] LCD_ADDR_L0   = 8'h80;
  localparam logic [7:0] LCD_ADDR_L1   = 8'hC0;

  function automatic logic [7:0] hex_char(
    input logic [3:0] v
  );
    logic [7:0] c;
    c = {4'h0, v};
    return (v < 4'd10) ? 8'h30 + c : 8'h37 + c;
  endfunction

  // '?' in a row template is replaced by the page number in hex
  function automatic logic [7:0] page_char(
    input logic [3:0] page,
    input logic       line,
    input logic [3:0] col
  );
    logic [127:0] row;
    logic [7:0]   c;
    row = line ? "LCD SEQUENCER P?" : "PAGE ?          ";
    c = row[8*(15-int'(col)) +: 8];
    if (c == 8'h3F) c = hex_char(page);
    return c;
  endfunction

endpackage

// File: rtl/lcd_page_sequencer_writer.sv
// Timed HD44780 byte writer: setup cycle, E pulse, then settle wait.
// Settle time is longer after the clear command.
module lcd_bus_writer
  import lcd_pkg::*;
#(
  parameter int EN_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [7:0] wr_data,
  input  logic       wr_rs,
  output logic [7:0] lcd_data,
  output logic       lcd_rs,
  output logic       lcd_en
);

  localparam int WMAX = (CLEAR_WAIT_CYC > CMD_WAIT_CYC) ?
                        CLEAR_WAIT_CYC : CMD_WAIT_CYC;
  localparam int CMAX = (WMAX > EN_PULSE_CYC) ? WMAX : EN_PULSE_CYC;
  localparam int CW   = $clog2(CMAX + 1);

  wr_state_e       st;
  wr_state_e       st_n;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   wait_last;
  logic            is_clr;

  assign wait_last = is_clr ? CW'(CLEAR_WAIT_CYC - 1)
                            : CW'(CMD_WAIT_CYC - 1);

  always_ff @(posedge clk) begin
    if (rst) st <= W_IDLE;
    else     st <= st_n;
  end

  always_comb begin
    st_n = st;
    unique case (st)
      W_IDLE:  if (wr_valid) st_n = W_SETUP;
      W_SETUP: st_n = W_EN;
      W_EN:    if (cnt == CW'(EN_PULSE_CYC - 1)) st_n = W_WAIT;
      W_WAIT:  if (cnt == wait_last) st_n = W_IDLE;
      default: st_n = W_IDLE;
    endcase
  end

  always_comb begin
    wr_ready = (st == W_IDLE);
    lcd_en   = (st == W_EN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      lcd_data <= '0;
      lcd_rs   <= 1'b0;
      is_clr   <= 1'b0;
    end else begin
      if (st_n != st || st == W_IDLE) cnt <= '0;
      else                            cnt <= cnt + 1'b1;
      if (st == W_IDLE && wr_valid) begin
        lcd_data <= wr_data;
        lcd_rs   <= wr_rs;
        is_clr   <= !wr_rs && (wr_data == LCD_CMD_CLEAR);
      end
    end
  end

endmodule

// File: rtl/lcd_page_sequencer.sv
// Page FSM: LCD init, page rendering and button-driven paging.
// Define LCD_BTN_DEBOUNCE_EN to debounce the buttons.
module lcd_page_sequencer
  import lcd_pkg::*;
#(
  parameter int POWERUP_CYC    = 750000,
  parameter int EN_PULSE_CYC   = 12,
  parameter int CMD_WAIT_CYC   = 2000,
  parameter int CLEAR_WAIT_CYC = 80000,
  parameter int NUM_PAGES      = 4,
  parameter int DEBOUNCE_CYC   = 500000,
  localparam int PW            = $clog2(NUM_PAGES)
) (
  input  logic          fpga_clk_i,
  input  logic          fpga_reset_i,
  input  logic          button_next_i,
  input  logic          button_prev_i,
  input  logic          button_ok_i,
  output logic          valid_o,
  output logic          busy_o,
  output logic [PW-1:0] page_o,
  output logic [7:0]    lcd_data_o,
  output logic          lcd_rs_o,
  output logic          lcd_enable_o
);

  localparam int PCW = $clog2(POWERUP_CYC + 1);

  lcd_state_e     state;
  lcd_state_e     state_n;
  lcd_ev_e        ev;
  lcd_ev_e        pend;
  lcd_ev_e        apply_ev;
  logic [PW-1:0]  page;
  logic [PCW-1:0] pw_cnt;
  logic [4:0]     idx;
  logic [2:0]     sync1;
  logic [2:0]     sync2;
  logic [2:0]     stab;
  logic [2:0]     stab_d;
  logic [2:0]     rise;
  logic           wr_valid;
  logic           wr_ready;
  logic           wr_acc;
  logic [7:0]     wr_data;
  logic           wr_rs;

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      sync1  <= '0;
      sync2  <= '0;
      stab_d <= '0;
    end else begin
      sync1  <= {button_ok_i, button_prev_i, button_next_i};
      sync2  <= sync1;
      stab_d <= stab;
    end
  end

`ifdef LCD_BTN_DEBOUNCE_EN
  localparam int DW = $clog2(DEBOUNCE_CYC + 1);
  logic [DW-1:0] db_cnt [3];

  // a button level is accepted only after DEBOUNCE_CYC equal samples
  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      stab <= '0;
      for (int i = 0; i < 3; i++) db_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (sync2[i] == stab[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DW'(DEBOUNCE_CYC - 1)) begin
          stab[i]   <= sync2[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign stab = sync2;
`endif

  assign rise = stab & ~stab_d;

  always_comb begin
    ev = EV_NONE;
    if (rise[0] && !rise[1])      ev = EV_NEXT;
    else if (rise[1] && !rise[0]) ev = EV_PREV;
    else if (rise[2])             ev = EV_OK;
  end

  always_comb begin
    apply_ev = EV_NONE;
    if (state == S_IDLE)
      apply_ev = (pend != EV_NONE) ? pend : ev;
  end

  assign wr_acc = wr_valid && wr_ready;

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) state <= S_PWRUP;
    else              state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_PWRUP:
        if (pw_cnt == PCW'(POWERUP_CYC - 1)) state_n = S_INIT;
      S_INIT:  if (wr_acc && idx == 5'd2) state_n = S_CLEAR;
      S_CLEAR: if (wr_acc) state_n = S_ADDR0;
      S_ADDR0: if (wr_acc) state_n = S_LINE0;
      S_LINE0: if (wr_acc && idx == 5'd15) state_n = S_ADDR1;
      S_ADDR1: if (wr_acc) state_n = S_LINE1;
      // last char must finish its settle time before reporting done
      S_LINE1: if (idx == 5'd16 && wr_ready) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      S_IDLE:  if (apply_ev != EV_NONE) state_n = S_CLEAR;
      default: state_n = S_PWRUP;
    endcase
  end

  always_comb begin
    wr_valid = 1'b0;
    wr_data  = '0;
    wr_rs    = 1'b0;
    valid_o  = (state == S_DONE);
    busy_o   = (state != S_IDLE);
    unique case (state)
      S_INIT: begin
        wr_valid = 1'b1;
        unique case (idx)
          5'd0:    wr_data = LCD_CMD_FUNC;
          5'd1:    wr_data = LCD_CMD_DISP;
          default: wr_data = LCD_CMD_ENTRY;
        endcase
      end
      S_CLEAR: begin
        wr_valid = 1'b1;
        wr_data  = LCD_CMD_CLEAR;
      end
      S_ADDR0: begin
        wr_valid = 1'b1;
        wr_data  = LCD_ADDR_L0;
      end
      S_LINE0: begin
        wr_valid = 1'b1;
        wr_rs    = 1'b1;
        wr_data  = page_char(4'(page), 1'b0, idx[3:0]);
      end
      S_ADDR1: begin
        wr_valid = 1'b1;
        wr_data  = LCD_ADDR_L1;
      end
      S_LINE1: begin
        wr_valid = !idx[4];
        wr_rs    = 1'b1;
        wr_data  = page_char(4'(page), 1'b1, idx[3:0]);
      end
      default: ;
    endcase
  end

  always_ff @(posedge fpga_clk_i) begin
    if (fpga_reset_i) begin
      page   <= '0;
      pend   <= EV_NONE;
      pw_cnt <= '0;
      idx    <= '0;
    end else begin
      case (apply_ev)
        EV_NEXT:
          page <= (page == PW'(NUM_PAGES - 1)) ? '0 : page + 1'b1;
        EV_PREV:
          page <= (page == '0) ? PW'(NUM_PAGES - 1) : page - 1'b1;
        default: ;
      endcase
      // one-deep pending slot, newest event wins
      if (state == S_IDLE && pend != EV_NONE) pend <= ev;
      else if (state != S_IDLE && ev != EV_NONE) pend <= ev;
      pw_cnt <= (state == S_PWRUP) ? pw_cnt + 1'b1 : '0;
      if (state_n != state) idx <= '0;
      else if (wr_acc)      idx <= idx + 1'b1;
    end
  end

  assign page_o = page;

  lcd_bus_writer #(
    .EN_PULSE_CYC  (EN_PULSE_CYC),
    .CMD_WAIT_CYC  (CMD_WAIT_CYC),
    .CLEAR_WAIT_CYC(CLEAR_WAIT_CYC)
  ) u_writer (
    .clk     (fpga_clk_i),
    .rst     (fpga_reset_i),
    .wr_valid(wr_valid),
    .wr_ready(wr_ready),
    .wr_data (wr_data),
    .wr_rs   (wr_rs),
    .lcd_data(lcd_data_o),
    .lcd_rs  (lcd_rs_o),
    .lcd_en  (lcd_enable_o)
  );

endmodule
